// File: rtl/fetch_stage_pkg.sv
// Shared RV32 fetch types: FSM state, buffered entry layout and core constants.
package fetch_stage_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned RV32_ILEN_B   = 4;
  localparam logic [31:0] RV32_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_DROP,
    FS_HALT
  } FetchState;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } FetchEntry;

  function automatic FetchEntry fault_entry(input logic [XLEN-1:0] pc);
    fault_entry = '{pc: pc, inst: RV32_NOP, fault: 1'b1};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer; the head is registered and drives the stage outputs directly.
module fetch_fifo
  import fetch_stage_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  FetchEntry i_push_entry,
  input  logic      i_pop,
  input  logic      i_flush,
  output logic [1:0] o_count,
  output FetchEntry o_head
);

  localparam FetchEntry EMPTY_ENTRY = '{pc: '0, inst: RV32_NOP, fault: 1'b0};

  FetchEntry  r_head, r_tail;
  logic [1:0] r_count;

  FetchEntry  w_head_n, w_tail_n;
  logic [1:0] w_count_n;
  logic       w_pop_ok, w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  // Flush wins over pop, but a same-cycle push lands in the freshly emptied buffer.
  always_comb begin
    w_head_n  = r_head;
    w_tail_n  = r_tail;
    w_count_n = r_count;
    if (i_flush) begin
      w_count_n = i_push ? 2'd1 : 2'd0;
      if (i_push) w_head_n = i_push_entry;
    end else begin
      if (w_pop_ok) begin
        w_head_n  = r_tail;
        w_count_n = r_count - 2'd1;
      end
      if (w_push_ok) begin
        if (w_count_n == 2'd0) w_head_n = i_push_entry;
        else                   w_tail_n = i_push_entry;
        w_count_n = w_count_n + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= EMPTY_ENTRY;
      r_tail  <= EMPTY_ENTRY;
      r_count <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding bus FSM with FIFO credit, and redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  FetchState   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_drop_fault;

  logic [1:0]  w_count;
  FetchEntry   w_head;
  logic        w_grant;
  logic        w_pop;
  logic        w_push;
  FetchEntry   w_push_entry;
  logic        w_misaligned;
  logic        w_busy_after;

  // Only REQ issues, and never while a response could be in flight, so count<2 is the credit.
  assign inst_req     = !rst && (r_state == FS_REQ) && (w_count != 2'd2);
  assign inst_addr    = rst ? RESET_PC : r_pc;
  assign w_grant      = inst_req && inst_gnt;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_busy_after = (((r_state == FS_WAIT) || (r_state == FS_DROP)) && !inst_rvalid) || w_grant;

  assign out_valid = (w_count != 2'd0);
  assign out_pc    = w_head.pc;
  assign out_inst  = w_head.inst;
  assign out_fault = w_head.fault;
  assign w_pop     = out_valid && out_ready && !redirect_en;

  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '{pc: r_inflight_pc, inst: inst_rdata, fault: 1'b0};
    if (redirect_en) begin
      if (!w_busy_after && w_misaligned) begin
        w_push       = 1'b1;
        w_push_entry = fault_entry(redirect_pc);
      end
    end else if (inst_rvalid) begin
      if (r_state == FS_WAIT) begin
        w_push = 1'b1;
      end else if ((r_state == FS_DROP) && r_drop_fault) begin
        w_push       = 1'b1;
        w_push_entry = fault_entry(r_pc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FS_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_drop_fault  <= 1'b0;
    end else if (redirect_en) begin
      r_pc         <= redirect_pc;
      r_drop_fault <= w_busy_after && w_misaligned;
      if (w_busy_after)      r_state <= FS_DROP;
      else if (w_misaligned) r_state <= FS_HALT;
      else                   r_state <= FS_REQ;
    end else begin
      case (r_state)
        FS_REQ: begin
          if (w_grant) begin
            r_state       <= FS_WAIT;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
          end
        end
        FS_WAIT: begin
          if (inst_rvalid) r_state <= FS_REQ;
        end
        FS_DROP: begin
          if (inst_rvalid) begin
            r_state      <= r_drop_fault ? FS_HALT : FS_REQ;
            r_drop_fault <= 1'b0;
          end
        end
        FS_HALT: begin
          r_state <= FS_HALT;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_en),
    .o_count      (w_count),
    .o_head       (w_head)
  );

endmodule
